// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction fetch stage.
package fetch_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned QDEPTH = 2;
  localparam int unsigned CNT_W  = 2;

  // addi x0,x0,0
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  // One fetched instruction together with the address it came from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of fetched {pc, inst} pairs feeding decode.
//   clk_i, reset_i : clock, synchronous active-high reset
//   push_i/entry_i : enqueue one entry (dropped if full and not popping)
//   pop_i          : dequeue the head entry (ignored when empty)
//   flush_i        : empty the queue; wins over push and pop
//   head_o         : head entry (ent0), count_o : number of valid entries
module fetch_queue
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_INST = 32'h0000_0013
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   push_i,
  input  fetch_entry_t           entry_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output fetch_entry_t           head_o,
  output logic [CNT_W-1:0]       count_o
);

  fetch_entry_t          ent0_q, ent0_d;
  fetch_entry_t          ent1_q, ent1_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  do_pop;
  logic                  do_push;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q < CNT_W'(QDEPTH)) || do_pop);

  // ent0 is always the head; a pop shifts ent1 down.
  always_comb begin
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (count_q == '0) ent0_d = entry_i;
          else               ent1_d = entry_i;
          count_d = count_q + CNT_W'(1);
        end
        2'b01: begin
          ent0_d  = ent1_q;
          count_d = count_q - CNT_W'(1);
        end
        2'b11: begin
          if (count_q == CNT_W'(1)) begin
            ent0_d = entry_i;
          end else begin
            ent0_d = ent1_q;
            ent1_d = entry_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ent0_q  <= '{pc: '0, inst: RESET_INST};
      ent1_q  <= '{pc: '0, inst: RESET_INST};
      count_q <= '0;
    end else begin
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
      count_q <= count_d;
    end
  end

  assign head_o  = ent0_q;
  assign count_o = count_q;

endmodule

// File: rtl/inst_fetch.sv
// RV32I fetch stage: pc register, single-outstanding imem request FSM,
// and a 2-entry queue presenting {inst, pc} to decode.
//   imem_req_*  : word fetch request (valid/ready), addr = pc register
//   imem_rsp_*  : in-order response, >= 1 cycle after acceptance
//   redirect_*  : taken branch/jump; flushes and refetches from redirect_pc
//   id_*        : head of the fetch queue toward decode (valid/ready)
module inst_fetch
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] NOP_INST = fetch_pkg::NOP_INST
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  output logic [XLEN-1:0] id_inst,
  output logic [XLEN-1:0] id_pc,
  input  logic            id_ready
);

  fetch_state_t      state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]  count;
  fetch_entry_t      head;
  logic              req_fire;
  logic              push;
  logic              flush;
  logic              unused_redirect_lsbs;

  // Request is a decode of registered state only; no input-to-output path.
  assign imem_req_valid = (state_q == REQ) && (count < CNT_W'(QDEPTH));
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Next-state / pc logic; redirect overrides everything below it.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    flush   = 1'b0;
    case (state_q)
      IDLE:  state_d = REQ;
      REQ:   if (req_fire) state_d = WAIT;
      WAIT: begin
        if (imem_rsp_valid) begin
          push    = 1'b1;
          pc_d    = pc_q + XLEN'(4);
          state_d = REQ;
        end
      end
      DRAIN: if (imem_rsp_valid) state_d = REQ;
      default: state_d = IDLE;
    endcase
    if (redirect_valid) begin
      flush = 1'b1;
      push  = 1'b0;
      pc_d  = {redirect_pc[XLEN-1:2], 2'b00};
      // A response is still owed to us if one is outstanding and not arriving now.
      if ((((state_q == WAIT) || (state_q == DRAIN)) && !imem_rsp_valid) ||
          ((state_q == REQ) && req_fire)) begin
        state_d = DRAIN;
      end else begin
        state_d = REQ;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_queue #(
    .RESET_INST (NOP_INST)
  ) u_queue (
    .clk_i   (clk),
    .reset_i (reset),
    .push_i  (push),
    .entry_i ('{pc: pc_q, inst: imem_rsp_data}),
    .pop_i   (id_valid && id_ready),
    .flush_i (flush),
    .head_o  (head),
    .count_o (count)
  );

  assign id_valid = (count != '0);
  assign id_inst  = head.inst;
  assign id_pc    = head.pc;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: cycle-driven memory model and a
// scoreboard of expected {pc, inst} entries popped as decode consumes them.
module tb_inst_fetch;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_req_addr, imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid, id_ready;
  logic [31:0] id_inst, id_pc;

  // Second instance for the RESET_PC wrap case.
  logic        w_req_valid, w_req_ready, w_rsp_valid;
  logic [31:0] w_req_addr, w_rsp_data;
  logic        w_redirect_valid, w_id_valid, w_id_ready;
  logic [31:0] w_redirect_pc, w_id_inst, w_id_pc;

  int n_pass  = 0;
  int n_total = 0;

  bit          drv_reset = 1'b1;
  bit          drv_redirect = 1'b0;
  logic [31:0] drv_redirect_pc = '0;
  bit          drv_id_ready = 1'b0;
  bit          mem_ready = 1'b1;
  int          mem_lat = 1;

  bit          pend = 1'b0;
  logic [31:0] pend_addr = '0;
  int          pend_wait = 0;
  bit          w_pend = 1'b0;
  logic [31:0] w_pend_addr = '0;

  exp_t        exp_q[$];
  logic [31:0] w_addrs[$];
  exp_t        w_ents[$];

  always #5 clk = ~clk;

  inst_fetch dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .id_valid(id_valid), .id_inst(id_inst),
    .id_pc(id_pc), .id_ready(id_ready)
  );

  inst_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .reset(reset),
    .imem_req_valid(w_req_valid), .imem_req_addr(w_req_addr),
    .imem_req_ready(w_req_ready), .imem_rsp_valid(w_rsp_valid),
    .imem_rsp_data(w_rsp_data), .redirect_valid(w_redirect_valid),
    .redirect_pc(w_redirect_pc), .id_valid(w_id_valid), .id_inst(w_id_inst),
    .id_pc(w_id_pc), .id_ready(w_id_ready)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0000) return 32'h0050_0093;
    if (a == 32'h0000_0004) return 32'h00A0_0113;
    return {a[19:0], 12'h013} ^ 32'h5A00_0000;
  endfunction

  // One cycle: at the falling edge apply staged inputs, run memory models,
  // and pop the scoreboard on a decode handshake.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    reset          = drv_reset;
    redirect_valid = drv_redirect;
    redirect_pc    = drv_redirect_pc;
    id_ready       = drv_id_ready;

    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'hDEAD_BEEF;
    if (pend) begin
      if (pend_wait == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend_addr);
        pend = 1'b0;
      end else begin
        pend_wait--;
      end
    end
    imem_req_ready = mem_ready;
    if (imem_req_valid === 1'b1 && mem_ready) begin
      n_total++;
      if (pend) $display("FAIL single_outstanding: got second request addr=%h, required none", imem_req_addr);
      else n_pass++;
      pend      = 1'b1;
      pend_addr = imem_req_addr;
      pend_wait = mem_lat - 1;
    end

    w_redirect_valid = 1'b0;
    w_redirect_pc    = '0;
    w_id_ready       = 1'b1;
    w_req_ready      = 1'b1;
    w_rsp_valid      = w_pend;
    w_rsp_data       = w_pend ? mem_word(w_pend_addr) : 32'hDEAD_BEEF;
    w_pend           = 1'b0;
    if (w_req_valid === 1'b1) begin
      w_pend      = 1'b1;
      w_pend_addr = w_req_addr;
      if (!drv_reset) w_addrs.push_back(w_req_addr);
    end
    if (!drv_reset && w_id_valid === 1'b1) w_ents.push_back({w_id_pc, w_id_inst});

    if (!drv_reset && !drv_redirect && drv_id_ready && id_valid === 1'b1) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_extra: got pc=%h inst=%h, required no entry", id_pc, id_inst);
      end else begin
        e = exp_q.pop_front();
        if ({id_pc, id_inst} !== e)
          $display("FAIL sb_entry: got pc=%h inst=%h, required pc=%h inst=%h", id_pc, id_inst, e.pc, e.inst);
        else n_pass++;
      end
    end
  endtask

  // Hold reset for several cycles (long enough to retire any stale model
  // response) and return in cycle 0, the first cycle with reset low.
  task automatic reset_release();
    drv_reset = 1'b1; drv_redirect = 1'b0; drv_id_ready = 1'b0;
    mem_ready = 1'b1; mem_lat = 1;
    repeat (5) tick();
    exp_q.delete(); w_addrs.delete(); w_ents.delete();
    drv_reset = 1'b0;
    tick();
  endtask

  task automatic run_until_drained(input int budget, output bit ok);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
    ok = (exp_q.size() == 0);
  endtask

  task automatic test_reset();
    drv_reset = 1'b1; drv_redirect = 1'b0; drv_id_ready = 1'b0;
    repeat (3) tick();
    n_total++; if (imem_req_valid !== 1'b0) $display("FAIL rst_req_valid: got %b, required 0", imem_req_valid); else n_pass++;
    n_total++; if (imem_req_addr !== 32'h0) $display("FAIL rst_req_addr: got %h, required 00000000", imem_req_addr); else n_pass++;
    n_total++; if (id_valid !== 1'b0) $display("FAIL rst_id_valid: got %b, required 0", id_valid); else n_pass++;
    n_total++; if (id_inst !== 32'h0000_0013) $display("FAIL rst_id_inst: got %h, required 00000013", id_inst); else n_pass++;
    n_total++; if (id_pc !== 32'h0) $display("FAIL rst_id_pc: got %h, required 00000000", id_pc); else n_pass++;
    n_total++; if (w_req_addr !== 32'hFFFF_FFFC) $display("FAIL rst_pc_param: got %h, required fffffffc", w_req_addr); else n_pass++;
    drv_reset = 1'b0;
    tick();
    n_total++; if (imem_req_valid !== 1'b0) $display("FAIL idle_c0: got req_valid %b, required 0", imem_req_valid); else n_pass++;
  endtask

  task automatic test_basic();
    bit ok;
    reset_release();
    drv_id_ready = 1'b1;
    exp_q.push_back('{pc: 32'h0, inst: 32'h0050_0093});
    exp_q.push_back('{pc: 32'h4, inst: 32'h00A0_0113});
    tick();
    n_total++; if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h0}) $display("FAIL basic_c1_req: got v=%b a=%h, required v=1 a=00000000", imem_req_valid, imem_req_addr); else n_pass++;
    tick();
    n_total++; if ({imem_req_valid, id_valid} !== 2'b00) $display("FAIL basic_c2: got req_valid=%b id_valid=%b, required 0 0", imem_req_valid, id_valid); else n_pass++;
    tick();
    n_total++; if ({id_valid, id_pc} !== {1'b1, 32'h0}) $display("FAIL basic_c3_id: got v=%b pc=%h, required v=1 pc=00000000", id_valid, id_pc); else n_pass++;
    run_until_drained(10, ok);
    drv_id_ready = 1'b0;
    n_total++; if (!ok) $display("FAIL basic_drain: got %0d entries left, required 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_stall();
    bit ok;
    reset_release();
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c >= 5) begin
        n_total++; if (imem_req_valid !== 1'b0) $display("FAIL stall_no_req c%0d: got %b, required 0", c, imem_req_valid); else n_pass++;
      end
    end
    n_total++; if ({id_valid, id_pc, id_inst} !== {1'b1, 32'h0, 32'h0050_0093}) $display("FAIL stall_head: got v=%b pc=%h inst=%h, required v=1 pc=0 inst=00500093", id_valid, id_pc, id_inst); else n_pass++;
    exp_q.push_back('{pc: 32'h0, inst: 32'h0050_0093});
    exp_q.push_back('{pc: 32'h4, inst: 32'h00A0_0113});
    exp_q.push_back('{pc: 32'h8, inst: mem_word(32'h8)});
    drv_id_ready = 1'b1;
    tick();
    n_total++; if (imem_req_valid !== 1'b0) $display("FAIL stall_c11_req: got %b, required 0", imem_req_valid); else n_pass++;
    tick();
    n_total++; if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h8}) $display("FAIL stall_resume: got v=%b a=%h, required v=1 a=00000008", imem_req_valid, imem_req_addr); else n_pass++;
    run_until_drained(20, ok);
    drv_id_ready = 1'b0;
    n_total++; if (!ok) $display("FAIL stall_drain: got %0d entries left, required 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_redirect_wait();
    bit ok;
    reset_release();
    tick(); tick();
    mem_lat = 3;
    tick();
    drv_redirect = 1'b1; drv_redirect_pc = 32'h0000_0103;
    tick();
    n_total++; if (id_valid !== 1'b1) $display("FAIL rw_pre: got id_valid %b, required 1", id_valid); else n_pass++;
    drv_redirect = 1'b0;
    tick();
    n_total++; if ({id_valid, imem_req_valid} !== 2'b00) $display("FAIL rw_flush: got id_valid=%b req_valid=%b, required 0 0", id_valid, imem_req_valid); else n_pass++;
    tick();
    mem_lat = 1; drv_id_ready = 1'b1;
    exp_q.push_back('{pc: 32'h100, inst: mem_word(32'h100)});
    tick();
    n_total++; if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h100}) $display("FAIL rw_req: got v=%b a=%h, required v=1 a=00000100", imem_req_valid, imem_req_addr); else n_pass++;
    run_until_drained(10, ok);
    drv_id_ready = 1'b0;
    n_total++; if (!ok) $display("FAIL rw_drain: got %0d entries left, required 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_redirect_rsp();
    bit ok;
    reset_release();
    tick();
    drv_redirect = 1'b1; drv_redirect_pc = 32'h0000_0040;
    tick();
    drv_redirect = 1'b0;
    tick();
    n_total++; if ({id_valid, imem_req_valid, imem_req_addr} !== {2'b01, 32'h40}) $display("FAIL rr_next: got id_v=%b req_v=%b a=%h, required 0 1 00000040", id_valid, imem_req_valid, imem_req_addr); else n_pass++;
    drv_id_ready = 1'b1;
    exp_q.push_back('{pc: 32'h40, inst: mem_word(32'h40)});
    run_until_drained(10, ok);
    drv_id_ready = 1'b0;
    n_total++; if (!ok) $display("FAIL rr_drain: got %0d entries left, required 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_redirect_req();
    bit ok;
    reset_release();
    mem_lat = 2;
    drv_redirect = 1'b1; drv_redirect_pc = 32'h0000_0080;
    tick();
    drv_redirect = 1'b0;
    tick();
    n_total++; if (imem_req_valid !== 1'b0) $display("FAIL rq_drain_state: got req_valid %b, required 0", imem_req_valid); else n_pass++;
    tick();
    mem_lat = 1; drv_id_ready = 1'b1;
    exp_q.push_back('{pc: 32'h80, inst: mem_word(32'h80)});
    tick();
    n_total++; if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h80}) $display("FAIL rq_req: got v=%b a=%h, required v=1 a=00000080", imem_req_valid, imem_req_addr); else n_pass++;
    run_until_drained(10, ok);
    drv_id_ready = 1'b0;
    n_total++; if (!ok) $display("FAIL rq_drain: got %0d entries left, required 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_ready_low();
    bit ok;
    reset_release();
    mem_ready = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      tick();
      n_total++; if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h0}) $display("FAIL rl_stable c%0d: got v=%b a=%h, required v=1 a=00000000", c, imem_req_valid, imem_req_addr); else n_pass++;
    end
    mem_ready = 1'b1; drv_id_ready = 1'b1;
    exp_q.push_back('{pc: 32'h0, inst: 32'h0050_0093});
    tick();
    n_total++; if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h0}) $display("FAIL rl_accept: got v=%b a=%h, required v=1 a=00000000", imem_req_valid, imem_req_addr); else n_pass++;
    run_until_drained(10, ok);
    drv_id_ready = 1'b0;
    n_total++; if (!ok) $display("FAIL rl_drain: got %0d entries left, required 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_reset_wait();
    bit ok;
    reset_release();
    tick(); tick();
    mem_lat = 2;
    tick();
    drv_reset = 1'b1;
    tick();
    drv_reset = 1'b0;
    tick();
    n_total++; if ({imem_req_valid, imem_req_addr} !== {1'b0, 32'h0}) $display("FAIL rwt_req: got v=%b a=%h, required v=0 a=00000000", imem_req_valid, imem_req_addr); else n_pass++;
    n_total++; if ({id_valid, id_pc, id_inst} !== {1'b0, 32'h0, 32'h0000_0013}) $display("FAIL rwt_id: got v=%b pc=%h inst=%h, required v=0 pc=0 inst=00000013", id_valid, id_pc, id_inst); else n_pass++;
    mem_lat = 1; drv_id_ready = 1'b1;
    exp_q.push_back('{pc: 32'h0, inst: 32'h0050_0093});
    tick();
    n_total++; if ({imem_req_valid, imem_req_addr, id_valid} !== {1'b1, 32'h0, 1'b0}) $display("FAIL rwt_refetch: got v=%b a=%h id_v=%b, required 1 00000000 0", imem_req_valid, imem_req_addr, id_valid); else n_pass++;
    run_until_drained(10, ok);
    drv_id_ready = 1'b0;
    n_total++; if (!ok) $display("FAIL rwt_drain: got %0d entries left, required 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_wrap();
    reset_release();
    repeat (8) tick();
    n_total++;
    if (w_addrs.size() < 2) $display("FAIL wrap_addr_count: got %0d requests, required >= 2", w_addrs.size());
    else if (w_addrs[0] !== 32'hFFFF_FFFC || w_addrs[1] !== 32'h0)
      $display("FAIL wrap_addr: got %h,%h, required fffffffc,00000000", w_addrs[0], w_addrs[1]);
    else n_pass++;
    n_total++;
    if (w_ents.size() < 2) $display("FAIL wrap_ent_count: got %0d entries, required >= 2", w_ents.size());
    else if (w_ents[0] !== {32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC)} || w_ents[1] !== {32'h0, 32'h0050_0093})
      $display("FAIL wrap_ent: got %h,%h, required pc fffffffc then 00000000", w_ents[0], w_ents[1]);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_redirect_wait();
    test_redirect_rsp();
    test_redirect_req();
    test_ready_low();
    test_reset_wait();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage of the RV32I core. It holds the program counter and issues word fetches to instruction memory over a valid/ready request channel with an in-order response channel. Fetched instructions are buffered in a 2-entry queue and presented to decode, which includes the immediate generator, as an `{inst, pc}` pair with a valid/ready handshake. A taken branch or jump from execute redirects the PC and flushes everything in flight.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value after reset.
- `NOP_INST`, default 32'h0000_0013 (`addi x0,x0,0`): reset value of the instruction storage.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `imem_req_valid` out 1: fetch request valid.
- `imem_req_addr` out 32: fetch byte address, always word-aligned.
- `imem_req_ready` in 1: memory accepts the request this cycle.
- `imem_rsp_valid` in 1: response valid; in order, at least 1 cycle after acceptance.
- `imem_rsp_data` in 32: fetched instruction word.
- `redirect_valid` in 1: taken branch or jump; flush and refetch.
- `redirect_pc` in 32: new PC; bits [1:0] are ignored and treated as 0.
- `id_valid` out 1: decode-side entry valid.
- `id_inst` out 32: instruction to decode (`inst_code` of the immediate generator).
- `id_pc` out 32: PC of `id_inst`.
- `id_ready` in 1: decode consumes the head entry this cycle.

## Operation
- FSM states:
  - IDLE: entered on reset; always goes to REQ next cycle.
  - REQ: issuing a request.
  - WAIT: one request outstanding.
  - DRAIN: outstanding response must be discarded.
- `imem_req_valid` = (state==REQ) && (count<2). `imem_req_addr` = pc register.
- REQ: on `imem_req_valid && imem_req_ready` go to WAIT.
- WAIT: on `imem_rsp_valid`, push `{pc, imem_rsp_data}` into the queue, set pc <= pc+4 (mod 2^32, wrapping FFFF_FFFC to 0000_0000) and go to REQ.
- DRAIN: on `imem_rsp_valid`, drop the data and go to REQ. pc is unchanged.
- At most one request is outstanding. `imem_rsp_valid` in IDLE or REQ is a protocol violation and is ignored.
- Queue: depth 2, with a count register. `id_valid` = count!=0. `id_inst`/`id_pc` come from the head entry. Pop on `id_valid && id_ready`. Push and pop in the same cycle are allowed; count stays the same.
- Redirect has top priority over every other event in the same cycle:
  - count <= 0 and pc <= {redirect_pc[31:2], 2'b00}.
  - Next state is DRAIN if the FSM is in WAIT without `imem_rsp_valid`, in DRAIN without `imem_rsp_valid`, or in REQ with the request accepted that cycle.
  - Otherwise the next state is REQ. A response arriving in the redirect cycle is discarded and is never pushed.
  - A pop requested in the redirect cycle is irrelevant, because the queue is cleared.
- Request withdrawal: `imem_req_valid` may only drop, or `imem_req_addr` change, before acceptance in the cycle after a redirect. Otherwise the request stays stable until it is accepted.

## Timing
- Reset values:
  - `imem_req_valid`=0, `imem_req_addr`=RESET_PC.
  - `id_valid`=0, `id_inst`=NOP_INST, `id_pc`=0.
  - pc=RESET_PC, count=0, state IDLE.
- Cycle 0 is the first cycle with reset low: IDLE. Cycle 1: `imem_req_valid`=1. With a zero-wait memory (ready at cycle 1, response at cycle 2), `id_valid`=1 at cycle 3.
- Steady-state throughput with a zero-wait memory: 1 instruction per 2 cycles.
- Redirect at cycle N: `id_valid`=0 at N+1. If no response is being drained, a request to redirect_pc appears at N+1.
- The queue is full at count==2: no request is issued. After a pop the count drops and REQ issues in the next cycle.
- Every output is a register or a decode of registered state. There is no combinational path from any input to any output.
- Reset asserted mid-operation: the next cycle is IDLE with all reset values, and any pending response is ignored.

## Structure
- `fetch_pkg`: `fetch_state_t` enum (IDLE, REQ, WAIT, DRAIN), `NOP_INST` constant, `XLEN`=32.
- Sub-module `fetch_queue`:
  - 2-entry FIFO of `{pc, inst}` with push, pop, flush and count.
  - Synchronous reset; entries reset to `{0, NOP_INST}`.
- `inst_fetch` contains the FSM, the pc register and the request/response logic.

## Test plan
- Reset release, always-ready memory returning 1-cycle responses 0x00500093, 0x00A00113: `id_valid` first rises at cycle 3 with `id_pc`=0x0/`id_inst`=0x00500093; the next entry is 0x4/0x00A00113.
- `id_ready`=0 held for 10 cycles: exactly 2 entries are queued (pc 0x0, 0x4), with no request while count==2. Releasing `id_ready` drains them in order, then fetching of 0x8 resumes.
- Redirect to 0x0000_0103 while in WAIT: `id_valid`=0 next cycle, the late response is discarded, and the next request has addr 0x100.
- Redirect in the same cycle as `imem_rsp_valid`: the data is not pushed, and a request to the new PC issues in the next cycle with no DRAIN.
- Memory holding `imem_req_ready` low for 5 cycles: `imem_req_valid` and `imem_req_addr` stay stable throughout.
- RESET_PC=0xFFFF_FFFC: the second request addr wraps to 0x0000_0000. Reset asserted while in WAIT: the state returns to IDLE and the stale response is ignored.
